jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Parametrised modulo-N up/down counter built from WIDTH JK storage cells. It is the multi-bit successor to the single JK flip-flop.
- Adds synchronous parallel load, count enable, direction control, a terminal-count flag and an optional saturate mode.
- Used as the lab-series counter primitive for dividers, BCD digits and sequencers.
- Clocked on the falling edge of clk, like the single JK cell it generalises.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 1.
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH (checked by elaboration-time assertion).
- RESET_VAL, 0, value forced by reset; must be < MODULUS.

Ports:
- clk, input, 1, clock; state updates on the falling edge.
- rst, input, 1, reset, asynchronous, active-low.
- en, input, 1, count enable.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load.
- d, input, WIDTH, load value.
- q, output, WIDTH, count value.
- nq, output, WIDTH, bitwise complement of q.
- tc, output, 1, terminal count (combinational).

Behaviour:
- Reset: rst low immediately forces q = RESET_VAL and nq = ~RESET_VAL, regardless of clk. All other inputs are ignored while rst is low.
- After rst rises, the first falling clk edge acts normally. Reset asserted mid-count overrides everything within the same delta.
- Priority at each falling edge: load > en > hold.
- load = 1:
  - d < MODULUS: q <= d.
  - d >= MODULUS: q <= 0 (out-of-range load is cleaned).
  - en and up are ignored.
- load = 0, en = 1, up = 1: q <= (q == MODULUS-1) ? 0 : q+1.
- load = 0, en = 1, up = 0: q <= (q == 0) ? MODULUS-1 : q-1.
- load = 0, en = 0: q holds.
- Latency: one falling edge from input to q; no pipelining.
- Per-bit realisation:
  - Each bit is a JK cell driven with J = next & ~q and K = ~next & q (combinational next-state).
  - With these drives a hold is JK = 00 and a toggle is never issued unless the bit actually changes.
- nq is always exactly ~q; the bank can never show q == nq.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)).
  - Combinational, so it is valid in the same cycle, before the wrap edge.
  - Cascade by feeding tc into the next stage's en.
- Direction change at a boundary:
  - q = 0 with up switched from 1 to 0 gives tc = 1 immediately.
  - The next edge then wraps q to MODULUS-1.
- MODULUS == 2**WIDTH: the wrap is natural binary overflow, with the same tc rules.
- No X propagation from d when load = 0.

Optional Feature:
- Macro: JK_COUNTER_SAT_EN.
- Defined: saturating mode.
  - At q == MODULUS-1 with up = 1 and en = 1, q holds.
  - At q == 0 with up = 0 and en = 1, q holds.
  - tc keeps the same definition, so it stays high for as long as the counter sits at its limit.
  - The load rule is unchanged.
- Undefined: wrap-around as described above.
- Port list is identical in both builds.

Decomposition:
- Package jk_pkg:
  - typedef jk_op_t, a 2-bit enum: JK_HOLD = 00, JK_RESET = 01, JK_SET = 10, JK_TOGGLE = 11.
  - Function jk_drive(cur, nxt) returning jk_op_t.
  - Localparam helper for the minimum width for a given modulus.
- Sub-module jk_cell:
  - One bit with ports clk, rst, J, K, Q, nQ.
  - Falling-edge clock, async active-low reset to a per-instance RESET_BIT parameter.
  - Instantiated WIDTH times in a generate loop.
- Next-state logic and tc live in jk_mod_counter.

Test Plan:
- Reset: WIDTH = 4, MODULUS = 10, RESET_VAL = 3. Pulse rst low between edges -> q = 3 and nq = 4'b1100 immediately, without waiting for a clk edge.
- Up wrap: en = 1, up = 1 from q = 0 -> q runs 1..9, then 0. tc = 1 only while q = 9. Exactly 10 edges per period.
- Down wrap: en = 1, up = 0 from q = 0 -> tc = 1 at q = 0, next q = 9, then 8, 7, and so on.
- Load: d = 7, load = 1, en = 1 -> q = 7 and tc = 0 in that cycle. Then d = 12, load = 1 -> q = 0.
- Mid-count reset and hold: count to 5, assert rst low half-period before the edge -> q = RESET_VAL, and the edge has no effect. Release rst, set en = 0 for 4 edges -> q is stable.
- JK_COUNTER_SAT_EN build: up-count from 8 -> 9, 9, 9 with tc held at 1. Down-count from 1 -> 0, 0, 0.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK-cell based modulo counter.
package jk_pkg;

    // JK input pair encoding, {J, K}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    // Smallest JK drive that moves a bit from cur to nxt; toggle is never
    // needed because the target value is always known.
    function automatic jk_op_t jk_drive(input logic cur, input logic nxt);
        if (cur == nxt) begin
            return JK_HOLD;
        end else if (nxt) begin
            return JK_SET;
        end else begin
            return JK_RESET;
        end
    endfunction

    // Minimum number of bits able to hold the values 0..modulus-1.
    function automatic int unsigned jk_min_width(input int unsigned modulus);
        if (modulus <= 2) begin
            return 1;
        end else begin
            return $clog2(modulus);
        end
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit: falling-edge clock, asynchronous active-low reset.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic nQ
);

    logic   q_q;
    logic   q_d;
    jk_op_t op;

    assign op = jk_op_t'({J, K});

    // Classic JK characteristic: hold, reset, set, toggle
    always_comb begin
        q_d = q_q;
        case (op)
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    // State bit, updated on the falling clock edge
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign nQ = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells.
// Falling-edge clocked, asynchronous active-low reset to RESET_VAL.
// Build option: define JK_COUNTER_SAT_EN to saturate at 0 / MODULUS-1
// instead of wrapping.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc
);

    localparam int               MIN_W = int'(jk_min_width(MODULUS));
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

    if (WIDTH < 1) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || WIDTH < MIN_W) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("jk_mod_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] ncnt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == MAX_V);
    assign at_zero = (cnt_q == '0);

    // Next count value: load beats enable beats hold; d only used on load
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = ({1'b0, d} < MOD_V) ? d : '0;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef JK_COUNTER_SAT_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef JK_COUNTER_SAT_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = MAX_V;
`endif
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // Each bit gets the JK drive that moves it from its present to its next value
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] drv;
        assign drv = jk_drive(cnt_q[gi], cnt_d[gi]);

        jk_cell #(
            .RESET_BIT (RST_V[gi])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .J   (drv[1]),
            .K   (drv[0]),
            .Q   (cnt_q[gi]),
            .nQ  (ncnt[gi])
        );
    end

    assign q  = cnt_q;
    assign nq = ncnt;
    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Testbench for jk_mod_counter: a MODULUS=10 instance (RESET_VAL=3) and a
// full-range MODULUS=16 instance (RESET_VAL=15) share the same stimulus and
// are checked against an arithmetic reference model.
module tb_jk_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] q10, nq10, q16, nq16;
    logic       tc10, tc16;

    int tests;
    int fails;
    int exp10;
    int exp16;

`ifdef JK_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    jk_mod_counter #(
        .WIDTH     (4),
        .MODULUS   (10),
        .RESET_VAL (3)
    ) u_dut10 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q10),
        .nq   (nq10),
        .tc   (tc10)
    );

    jk_mod_counter #(
        .WIDTH     (4),
        .MODULUS   (16),
        .RESET_VAL (15)
    ) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q16),
        .nq   (nq16),
        .tc   (tc16)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Reference: next value of a modulo-mod counter from the behavioural rules
    function automatic int model_next(int cur, int mod, bit ld, bit e, bit u, int dv);
        if (ld) return (dv < mod) ? dv : 0;
        if (!e) return cur;
        if (u) begin
            if (cur == mod - 1) return SAT ? cur : 0;
            return cur + 1;
        end
        if (cur == 0) return SAT ? 0 : mod - 1;
        return cur - 1;
    endfunction

    function automatic bit model_tc(int cur, int mod, bit ld, bit e, bit u);
        return e && !ld && ((u && cur == mod - 1) || (!u && cur == 0));
    endfunction

    // Applies one falling edge with the current inputs and advances the model;
    // returns 1 ns after the following rising edge.
    task automatic step();
        int n10, n16;
        n10 = model_next(exp10, 10, load, en, up, int'(d));
        n16 = model_next(exp16, 16, load, en, up, int'(d));
        @(negedge clk);
        exp10 = n10;
        exp16 = n16;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
        #1 rst = 1'b0;
        #1;
        tests++;
        if (q10 !== 4'd3 || nq10 !== 4'b1100) begin
            fails++;
            $display("FAIL reset_async10: q=%0d nq=%b, want q=3 nq=1100", q10, nq10);
        end
        tests++;
        if (q16 !== 4'd15 || nq16 !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async16: q=%0d nq=%b, want q=15 nq=0000", q16, nq16);
        end
        @(posedge clk);
        #1;
        tests++;
        if (q10 !== 4'd3 || q16 !== 4'd15) begin
            fails++;
            $display("FAIL reset_hold_edge: q10=%0d q16=%0d, want 3 and 15", q10, q16);
        end
        rst = 1'b1;
        exp10 = 3;
        exp16 = 15;
    endtask

    task automatic test_up_wrap();
        int last_zero;
        load = 1'b1; d = 4'd0; en = 1'b0; up = 1'b1;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        last_zero = 0;
        for (int i = 1; i <= 25; i++) begin
            #1;
            tests++;
            if (tc10 !== model_tc(exp10, 10, load, en, up) || tc16 !== model_tc(exp16, 16, load, en, up)) begin
                fails++;
                $display("FAIL up_tc: cycle %0d q10=%0d tc10=%b q16=%0d tc16=%b", i, q10, tc10, q16, tc16);
            end
            step();
            tests++;
            if (q10 !== 4'(exp10) || nq10 !== ~4'(exp10) || q16 !== 4'(exp16) || nq16 !== ~4'(exp16)) begin
                fails++;
                $display("FAIL up_count: cycle %0d q10=%0d nq10=%b q16=%0d nq16=%b, want %0d / %0d",
                         i, q10, nq10, q16, nq16, exp10, exp16);
            end
            if (q10 === 4'd0) begin
                if (!SAT) begin
                    tests++;
                    if (i - last_zero != 10) begin
                        fails++;
                        $display("FAIL up_period: %0d edges between zeros, want 10", i - last_zero);
                    end
                end
                last_zero = i;
            end
        end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; d = 4'd0; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 13; i++) begin
            #1;
            tests++;
            if (tc10 !== model_tc(exp10, 10, load, en, up) || tc16 !== model_tc(exp16, 16, load, en, up)) begin
                fails++;
                $display("FAIL down_tc: cycle %0d q10=%0d tc10=%b q16=%0d tc16=%b", i, q10, tc10, q16, tc16);
            end
            step();
            tests++;
            if (q10 !== 4'(exp10) || nq10 !== ~4'(exp10) || q16 !== 4'(exp16) || nq16 !== ~4'(exp16)) begin
                fails++;
                $display("FAIL down_count: cycle %0d q10=%0d q16=%0d, want %0d / %0d", i, q10, q16, exp10, exp16);
            end
        end
    endtask

    task automatic test_load();
        load = 1'b1; d = 4'd9; en = 1'b0;
        step();
        load = 1'b1; d = 4'd7; en = 1'b1; up = 1'b1;
        #1;
        tests++;
        if (tc10 !== 1'b0 || tc16 !== 1'b0) begin
            fails++;
            $display("FAIL load_tc: tc10=%b tc16=%b at q10=%0d, want 0 0", tc10, tc16, q10);
        end
        step();
        tests++;
        if (q10 !== 4'd7 || q16 !== 4'd7) begin
            fails++;
            $display("FAIL load_in_range: q10=%0d q16=%0d, want 7 7", q10, q16);
        end
        d = 4'd12;
        step();
        tests++;
        if (q10 !== 4'd0 || q16 !== 4'd12 || nq10 !== 4'b1111) begin
            fails++;
            $display("FAIL load_out_of_range: q10=%0d nq10=%b q16=%0d, want 0 1111 12", q10, nq10, q16);
        end
    endtask

    task automatic test_mid_reset_hold();
        load = 1'b1; d = 4'd0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (q10 !== 4'd5 || q16 !== 4'd5) begin
            fails++;
            $display("FAIL pre_reset_count: q10=%0d q16=%0d, want 5 5", q10, q16);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (q10 !== 4'd3 || nq10 !== 4'b1100 || q16 !== 4'd15) begin
            fails++;
            $display("FAIL mid_reset_async: q10=%0d nq10=%b q16=%0d, want 3 1100 15", q10, nq10, q16);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (q10 !== 4'd3 || q16 !== 4'd15) begin
            fails++;
            $display("FAIL mid_reset_edge: q10=%0d q16=%0d, want 3 15", q10, q16);
        end
        rst = 1'b1;
        exp10 = 3;
        exp16 = 15;
        en = 1'b0;
        d = 4'bxxxx;
        for (int i = 0; i < 4; i++) begin
            up = 1'($urandom_range(0, 1));
            step();
            tests++;
            if (q10 !== 4'd3 || nq10 !== 4'b1100 || q16 !== 4'd15) begin
                fails++;
                $display("FAIL hold: edge %0d q10=%0d nq10=%b q16=%0d, want 3 1100 15", i, q10, nq10, q16);
            end
        end
        d = 4'd0;
    endtask

    task automatic test_boundary();
        load = 1'b1; d = 4'd8; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (tc10 !== model_tc(exp10, 10, load, en, up)) begin
                fails++;
                $display("FAIL limit_up_tc: step %0d q10=%0d tc10=%b", i, q10, tc10);
            end
            step();
            tests++;
            if (q10 !== 4'(exp10) || q16 !== 4'(exp16)) begin
                fails++;
                $display("FAIL limit_up: step %0d q10=%0d q16=%0d, want %0d / %0d", i, q10, q16, exp10, exp16);
            end
        end
        load = 1'b1; d = 4'd1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (tc10 !== model_tc(exp10, 10, load, en, up) || tc16 !== model_tc(exp16, 16, load, en, up)) begin
                fails++;
                $display("FAIL limit_down_tc: step %0d q10=%0d tc10=%b tc16=%b", i, q10, tc10, tc16);
            end
            step();
            tests++;
            if (q10 !== 4'(exp10) || q16 !== 4'(exp16)) begin
                fails++;
                $display("FAIL limit_down: step %0d q10=%0d q16=%0d, want %0d / %0d", i, q10, q16, exp10, exp16);
            end
        end
        // direction flip at zero raises tc straight away
        load = 1'b1; d = 4'd0; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        up = 1'b0;
        #1;
        tests++;
        if (tc10 !== 1'b1 || tc16 !== 1'b1) begin
            fails++;
            $display("FAIL dir_flip_tc: tc10=%b tc16=%b, want 1 1", tc10, tc16);
        end
        step();
        tests++;
        if (q10 !== 4'(exp10) || q16 !== 4'(exp16)) begin
            fails++;
            $display("FAIL dir_flip_wrap: q10=%0d q16=%0d, want %0d / %0d", q10, q16, exp10, exp16);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en   = 1'($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 7) == 0);
            d    = 4'($urandom_range(0, 15));
            #1;
            tests++;
            if (tc10 !== model_tc(exp10, 10, load, en, up) || tc16 !== model_tc(exp16, 16, load, en, up)) begin
                fails++;
                $display("FAIL rand_tc: cycle %0d q10=%0d tc10=%b q16=%0d tc16=%b en=%b up=%b load=%b",
                         i, q10, tc10, q16, tc16, en, up, load);
            end
            step();
            tests++;
            if (q10 !== 4'(exp10) || nq10 !== ~4'(exp10) || q16 !== 4'(exp16) || nq16 !== ~4'(exp16)) begin
                fails++;
                $display("FAIL rand_q: cycle %0d q10=%0d nq10=%b q16=%0d nq16=%b, want %0d / %0d",
                         i, q10, nq10, q16, nq16, exp10, exp16);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp10 = 3;
        exp16 = 15;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_mid_reset_hold();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
